// File: rtl/aes192_cipher_iter.sv
// Iterative AES-192 encryption core: one round per clock over an externally
// supplied, externally held 13-round-key schedule, valid/ready on both sides.
`timescale 1ns/1ps

module aes192_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TABLE[{a, 3'b000} +: 8];
endmodule

module aes192_cipher_iter #(
  parameter int NR = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:127]           plaintext,
  input  logic [0:128*(NR+1)-1]  keyschedule,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:127]           ciphertext,
  output logic                   busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [3:0] LAST  = 4'(NR);

  logic [1:0]   state;
  logic [3:0]   rnd;
  logic [3:0]   rk_idx;
  logic [0:127] state_reg;
  logic [0:127] sub_bytes;
  logic [0:127] shifted;
  logic [0:127] mixed;
  logic [0:127] round_key;
  logic [0:127] next_block;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Clamped so an out-of-range counter never indexes past the schedule.
  assign rk_idx    = (rnd > LAST) ? LAST : rnd;
  assign round_key = keyschedule[{rk_idx, 7'b0000000} +: 128];

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes192_sbox u_sbox (
      .a (state_reg[8*i +: 8]),
      .y (sub_bytes[8*i +: 8])
    );
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[8*(4*c+r) +: 8] = sub_bytes[8*(4*((c+r)%4)+r) +: 8];
      end
    end
  end

  always_comb begin : mix_columns
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = shifted[32*c      +: 8];
      a1 = shifted[32*c + 8  +: 8];
      a2 = shifted[32*c + 16 +: 8];
      a3 = shifted[32*c + 24 +: 8];
      mixed[32*c      +: 8] = xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3;
      mixed[32*c + 8  +: 8] = xtime(a1 ^ a2) ^ a0 ^ a2 ^ a3;
      mixed[32*c + 16 +: 8] = xtime(a2 ^ a3) ^ a0 ^ a1 ^ a3;
      mixed[32*c + 24 +: 8] = xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2;
    end
  end

  assign next_block = ((rnd == LAST) ? shifted : mixed) ^ round_key;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= '0;
      state_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= plaintext ^ keyschedule[0 +: 128];
            rnd       <= 4'd1;
            state     <= ROUND;
          end
        end
        ROUND: begin
          if (rnd > LAST) begin
            state <= IDLE;
            rnd   <= '0;
          end else begin
            state_reg <= next_block;
            if (rnd == LAST) begin
              state <= DONE;
              rnd   <= '0;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          rnd   <= '0;
        end
      endcase
    end
  end

  // Intermediate round values are masked so a partial result is never visible.
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign ciphertext = (state == DONE) ? state_reg : '0;
endmodule

// File: tb/tb_aes192_cipher_iter.sv
// Scoreboard bench for aes192_cipher_iter: directed FIPS/known-answer vectors,
// handshake and reset scenarios, plus a reference model for random traffic.
`timescale 1ns/1ps

module tb_aes192_cipher_iter;
  localparam logic [0:191] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [0:127] PT_C2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT_ZERO = 128'haae06992acbf52a3e8f4a96ec9300bd7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [0:127]  plaintext;
  logic [0:1663] keyschedule;
  logic          out_valid;
  logic          out_ready;
  logic [0:127]  ciphertext;
  logic          busy;

  aes192_cipher_iter dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .plaintext   (plaintext),
    .keyschedule (keyschedule),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ciphertext  (ciphertext),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_out    = 0;
  int           cyc      = 0;
  logic [0:127] exp_q [$];
  logic [7:0]   sb [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine transform.
  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
      sb[a] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [0:1663] expand(input logic [0:191] key);
    logic [31:0]   w [52];
    logic [31:0]   t;
    logic [7:0]    rcon = 8'h01;
    logic [0:1663] ks;
    for (int i = 0; i < 6; i++) w[i] = key[32*i +: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h000000};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int i = 0; i < 52; i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [0:127] model_enc(input logic [0:127] pt, input logic [0:1663] ks);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [0:127] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[8*(4*c+r) +: 8] ^ ks[8*(4*c+r) +: 8];
    for (int rd = 1; rd <= 12; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 12) begin
          s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
          s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] ^= ks[128*rd + 8*(4*c+r) +: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[8*(4*c+r) +: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- monitor ----------------
  logic ov_d      = 1'b0;
  logic have_acc  = 1'b0;
  logic have_hs   = 1'b0;
  logic tput_mode = 1'b0;
  logic b2b_mode  = 1'b0;
  int   acc_edge  = 0;
  int   hs_edge   = 0;

  always @(negedge clk) begin
    if (rst) begin
      ov_d     = 1'b0;
      have_acc = 1'b0;
      have_hs  = 1'b0;
    end else begin
      if (out_valid && !ov_d && have_acc)
        check("latency_edges", 128'(cyc - acc_edge + 1), 128'd13);
      ov_d = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 128'(ciphertext), 128'hx);
        end else begin
          check("ciphertext", 128'(ciphertext), 128'(exp_q.pop_front()));
        end
        n_out++;
        hs_edge = cyc + 1;
        have_hs = 1'b1;
      end
      if (in_valid && in_ready) begin
        if (tput_mode && have_acc)
          check("throughput_cycles", 128'(cyc + 1 - acc_edge), 128'd14);
        if (b2b_mode && have_hs)
          check("accept_after_handshake", 128'(cyc + 1 - hs_edge), 128'd1);
        acc_edge = cyc + 1;
        have_acc = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_accept();
    logic seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) seen = 1'b1;
    end
    if (!seen) check("accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_hs();
    logic seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) seen = 1'b1;
    end
    if (!seen) check("output_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_one(input logic [0:127] pt, input logic [0:191] key, input logic [0:127] exp_ct);
    plaintext   = pt;
    keyschedule = expand(key);
    in_valid    = 1'b1;
    wait_accept();
    exp_q.push_back(exp_ct);
    in_valid = 1'b0;
    wait_out_hs();
  endtask

  initial begin : stim
    logic [0:191]  key;
    logic [0:127]  pt;
    logic [0:127]  pt2;
    logic          seen;
    int            out_before;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = '0; keyschedule = '0;
    build_sbox();
    #12;
    check("reset_in_ready",   128'(in_ready),   128'd1);
    check("reset_out_valid",  128'(out_valid),  128'd0);
    check("reset_busy",       128'(busy),       128'd0);
    check("reset_ciphertext", 128'(ciphertext), 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // C.2 vector, held at the output for 20 cycles before a one-cycle out_ready pulse.
    plaintext   = PT_C2;
    keyschedule = expand(KEY_C2);
    in_valid    = 1'b1;
    wait_accept();
    exp_q.push_back(CT_C2);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) check("c2_done_timeout", 128'd0, 128'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_out_valid",  128'(out_valid),  128'd1);
      check("hold_ciphertext", 128'(ciphertext), 128'(CT_C2));
      check("hold_in_ready",   128'(in_ready),   128'd0);
      check("hold_busy",       128'(busy),       128'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("pulse_in_ready",  128'(in_ready),  128'd1);
    check("pulse_out_valid", 128'(out_valid), 128'd0);
    check("pulse_busy",      128'(busy),      128'd0);

    // Second plaintext presented continuously while the first is in flight.
    out_ready   = 1'b1;
    out_before  = n_out;
    pt2         = 128'hffeeddccbbaa99887766554433221100;
    plaintext   = PT_C2;
    keyschedule = expand(KEY_C2);
    in_valid    = 1'b1;
    wait_accept();
    exp_q.push_back(CT_C2);
    plaintext = pt2;
    b2b_mode  = 1'b1;
    wait_accept();
    exp_q.push_back(model_enc(pt2, keyschedule));
    in_valid = 1'b0;
    b2b_mode = 1'b0;
    wait_out_hs();
    repeat (3) @(posedge clk); #1;
    check("two_results", 128'(n_out - out_before), 128'd2);

    // Reset at round 6 discards the block; a fresh run still matches.
    plaintext   = PT_C2;
    keyschedule = expand(KEY_C2);
    in_valid    = 1'b1;
    wait_accept();
    exp_q.push_back(CT_C2);
    in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("mid_busy",     128'(busy),     128'd1);
    check("mid_in_ready", 128'(in_ready), 128'd0);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid",  128'(out_valid),  128'd0);
    check("abort_in_ready",   128'(in_ready),   128'd1);
    check("abort_busy",       128'(busy),       128'd0);
    check("abort_ciphertext", 128'(ciphertext), 128'd0);
    void'(exp_q.pop_back());
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    run_one(PT_C2, KEY_C2, CT_C2);

    // AES-192 all-zero known answer.
    run_one('0, '0, CT_ZERO);

    // Random traffic with in_valid and out_ready held high.
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      plaintext   = pt;
      keyschedule = expand(key);
      wait_accept();
      exp_q.push_back(model_enc(pt, keyschedule));
      if (n == 0) tput_mode = 1'b1;
      wait_out_hs();
      if (n == 49) in_valid = 1'b0;
    end
    tput_mode = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    check("total_outputs", 128'(n_out), 128'd55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
